pin_entry_collector: RTL and testbench
======================================

// Module: pin_entry_collector
// PURPOSE
//   Keypad front-end for the ATM controller. Collects decimal PIN digits from the keypad while a card is present.
//   Supports backspace, clear, cancel and an inactivity timeout.
//   On ENTER, converts the digits to a binary value and presents it for one cycle on pin_value/pin_valid.
//   The ATM controller compares that value against the stored visa password.
// PARAMETERS
//   NUM_DIGITS      4        PIN length in digits (exactly this many required on ENTER)
//   PIN_W           14       width of pin_value; must satisfy 10**NUM_DIGITS-1 < 2**PIN_W
//   TIMEOUT_CYCLES  1000000  idle cycles in ENTRY before timeout fires
//   TMR_W           20       timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//   clk          in   1      single system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   card_present in   1      level; high while card is inserted
//   key_valid    in   1      one-cycle strobe, key_code valid
//   key_code     in   4      0-9 digit, A=CLEAR, B=BACKSPACE, C=ENTER, D=CANCEL, E/F ignored
//   pin_value    out  PIN_W  binary PIN, valid only while pin_valid=1, else 0
//   pin_valid    out  1      one-cycle pulse, PIN ready
//   pin_error    out  1      one-cycle pulse, ENTER with digit_count != NUM_DIGITS
//   pin_cancel   out  1      one-cycle pulse, CANCEL key accepted
//   pin_timeout  out  1      one-cycle pulse, inactivity timeout
//   digit_count  out  3      digits currently buffered (for display masking)
//   busy         out  1      high in CONVERT and DONE
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; digit buffer, accumulator and timer cleared.
//   States: IDLE, ENTRY, CONVERT, DONE.
//   IDLE -> ENTRY when card_present=1. Buffer is empty and timer is 0 on entry.
//   ENTRY: one key is processed per key_valid cycle; a key restarts the timer to 0.
//     digit: appended if digit_count<NUM_DIGITS; silently dropped if full (timer still restarts).
//     BACKSPACE: removes the last digit; ignored if empty.
//     CLEAR: empties the buffer.
//     ENTER: if digit_count==NUM_DIGITS, go to CONVERT. Otherwise pulse pin_error next cycle, clear the buffer, stay in ENTRY.
//     CANCEL: pulse pin_cancel next cycle, clear the buffer, stay in ENTRY.
//     E/F: ignored, timer not restarted.
//     No key: timer increments. At TIMEOUT_CYCLES-1 -> pin_timeout pulse next cycle, buffer cleared, timer 0, stay in ENTRY.
//     A key arriving in the expiry cycle wins; no timeout is generated that cycle.
//   CONVERT: exactly NUM_DIGITS cycles, most-significant digit first.
//     Each cycle: acc <= acc*10 + digit[i], computed in PIN_W bits; no overflow is possible by the parameter constraint.
//     key_valid is ignored; the timer is held at 0.
//   DONE: one cycle; pin_valid=1, pin_value=acc; then buffer cleared and back to ENTRY (ready for retry).
//   Latency: ENTER sampled at edge T -> pin_valid high in cycle T+NUM_DIGITS+1 (registered output).
//   Card removal: card_present=0 in any state -> IDLE next cycle.
//     Buffer cleared; no pin_valid/pin_error/pin_cancel/pin_timeout is generated, including a conversion in flight.
//   Reset mid-CONVERT: aborts; no pin_valid is produced.
//   Pulse outputs are mutually exclusive; at most one is high in any cycle.
//   digit_count updates in the cycle after the key; it is 0 in IDLE and after any clear.
// TESTING
//   1. card in; keys 8,0,3,0,ENTER -> pin_valid=1 exactly 5 cycles after ENTER edge, pin_value=14'd8030, digit_count=0 after.
//   2. keys 1,2,BKSP,5,6,7,ENTER -> pin_value=1567; keys 9,9,ENTER -> pin_error pulse, no pin_valid, digit_count=0.
//   3. keys 1,2,3,4,5 -> digit_count stays 4; ENTER -> pin_value=1234; BKSP on empty buffer -> digit_count stays 0.
//   4. TIMEOUT_CYCLES=16: key 7 then idle 16 cycles -> single pin_timeout pulse, digit_count=0.
//      Key exactly in the expiry cycle -> no timeout.
//   5. ENTER on 4 digits, then drop card_present during CONVERT -> no pin_valid, state IDLE, all outputs 0.
//   6. CANCEL mid-entry -> pin_cancel pulse, buffer cleared; keys during CONVERT are ignored (value unchanged).

Source files
------------

// File: rtl/pin_entry_collector.sv
// Keypad PIN collector: buffers decimal digits while a card is inserted, then
// converts them to binary on ENTER and pulses the result for one cycle.
module pin_entry_collector #(
    parameter int NUM_DIGITS     = 4,
    parameter int PIN_W          = 14,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMR_W          = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_present,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [PIN_W-1:0] pin_value,
    output logic             pin_valid,
    output logic             pin_error,
    output logic             pin_cancel,
    output logic             pin_timeout,
    output logic [2:0]       digit_count,
    output logic             busy
);
    // state   | meaning
    // IDLE    | no card; buffer empty, all pulses low
    // ENTRY   | collecting keys, inactivity timer running
    // CONVERT | folding buffered digits into acc, MSD first
    // DONE    | pin_valid/pin_value presented for one cycle
    typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, DONE} state_t;

    localparam int               IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [2:0]       FULL      = 3'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       KEY_CLEAR = 4'hA;
    localparam logic [3:0]       KEY_BKSP  = 4'hB;
    localparam logic [3:0]       KEY_ENTER = 4'hC;

    state_t           state;
    logic [3:0]       digits [NUM_DIGITS];
    logic [2:0]       count;
    logic [IDX_W-1:0] conv_idx;
    logic [PIN_W-1:0] acc;
    logic [PIN_W-1:0] acc_next;
    logic [TMR_W-1:0] timer;
    logic             key_live;

    // E/F never count as activity, so they fall through to the timer path
    assign key_live    = key_valid && (key_code < 4'hE);
    assign acc_next    = acc * PIN_W'(10) + PIN_W'(digits[conv_idx]);
    assign digit_count = count;
    assign busy        = (state == CONVERT) || (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            conv_idx    <= '0;
            acc         <= '0;
            timer       <= '0;
            pin_value   <= '0;
            pin_valid   <= 1'b0;
            pin_error   <= 1'b0;
            pin_cancel  <= 1'b0;
            pin_timeout <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
        end else begin
            pin_value   <= '0;
            pin_valid   <= 1'b0;
            pin_error   <= 1'b0;
            pin_cancel  <= 1'b0;
            pin_timeout <= 1'b0;
            // card removal overrides everything, including a conversion in flight
            if (!card_present) begin
                state    <= IDLE;
                count    <= '0;
                conv_idx <= '0;
                acc      <= '0;
                timer    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ENTRY;
                        count <= '0;
                        timer <= '0;
                    end
                    ENTRY: begin
                        if (key_live) begin
                            timer <= '0;
                            if (key_code <= 4'd9) begin
                                if (count < FULL) begin
                                    digits[count[IDX_W-1:0]] <= key_code;
                                    count <= count + 3'd1;
                                end
                            end else begin
                                case (key_code)
                                    KEY_CLEAR: count <= '0;
                                    KEY_BKSP: if (count != 3'd0) count <= count - 3'd1;
                                    KEY_ENTER: begin
                                        if (count == FULL) begin
                                            state    <= CONVERT;
                                            acc      <= '0;
                                            conv_idx <= '0;
                                        end else begin
                                            pin_error <= 1'b1;
                                            count     <= '0;
                                        end
                                    end
                                    default: begin
                                        pin_cancel <= 1'b1;
                                        count      <= '0;
                                    end
                                endcase
                            end
                        end else if (timer == TMR_LAST) begin
                            pin_timeout <= 1'b1;
                            count       <= '0;
                            timer       <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    CONVERT: begin
                        acc      <= acc_next;
                        conv_idx <= conv_idx + IDX_W'(1);
                        timer    <= '0;
                        if (conv_idx == LAST_IDX) begin
                            state     <= DONE;
                            pin_valid <= 1'b1;
                            pin_value <= acc_next;
                        end
                    end
                    DONE: begin
                        state <= ENTRY;
                        count <= '0;
                        timer <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pin_entry_collector.sv
// Scoreboard bench for pin_entry_collector: a cycle-level behavioural model
// predicts every output pulse; a negedge monitor pops and compares them.
module tb_pin_entry_collector;
    localparam int ND = 4;
    localparam int PW = 14;
    localparam int TO = 16;
    localparam int TW = 5;

    localparam int K_VALID = 0, K_ERROR = 1, K_CANCEL = 2, K_TIMEOUT = 3;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_CONV = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          card_present = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'h0;
    logic [PW-1:0] pin_value;
    logic          pin_valid, pin_error, pin_cancel, pin_timeout, busy;
    logic [2:0]    digit_count;

    pin_entry_collector #(.NUM_DIGITS(ND), .PIN_W(PW), .TIMEOUT_CYCLES(TO), .TMR_W(TW)) dut (
        .clk(clk), .reset(reset), .card_present(card_present), .key_valid(key_valid),
        .key_code(key_code), .pin_value(pin_value), .pin_valid(pin_valid), .pin_error(pin_error),
        .pin_cancel(pin_cancel), .pin_timeout(pin_timeout), .digit_count(digit_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int value; int edge_at;} exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;

    // reference model: buffer as a queue of digits, mode and counters as plain ints
    int m_mode = M_IDLE;
    int m_digits[$];
    int m_idle = 0;
    int m_conv_left = 0;
    int m_pin = 0;

    int n_valid = 0, n_error = 0, n_cancel = 0, n_timeout = 0, last_value = -1;

    function automatic int pin_of(input int d[$]);
        int v = 0, w = 1;
        for (int i = d.size() - 1; i >= 0; i--) begin
            v += d[i] * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic void push_exp(input int kind, input int value);
        exp_t e;
        e.kind = kind; e.value = value; e.edge_at = edge_n;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_digits.delete(); m_idle = 0; m_conv_left = 0;
    endfunction

    function automatic void model_step(input bit kv, input int kc, input bit cp);
        if (!cp) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: begin m_mode = M_ENTRY; m_digits.delete(); m_idle = 0; end
            M_CONV: begin
                m_conv_left--;
                if (m_conv_left == 0) begin
                    push_exp(K_VALID, m_pin);
                    m_mode = M_DONE;
                end
            end
            M_DONE: begin m_mode = M_ENTRY; m_digits.delete(); m_idle = 0; end
            default: begin
                if (kv && kc <= 13) begin
                    m_idle = 0;
                    if (kc <= 9) begin
                        if (m_digits.size() < ND) m_digits.push_back(kc);
                    end else if (kc == 10) m_digits.delete();
                    else if (kc == 11) begin
                        if (m_digits.size() > 0) void'(m_digits.pop_back());
                    end else if (kc == 12) begin
                        if (m_digits.size() == ND) begin
                            m_pin = pin_of(m_digits);
                            m_conv_left = ND;
                            m_mode = M_CONV;
                        end else begin
                            push_exp(K_ERROR, 0);
                            m_digits.delete();
                        end
                    end else begin
                        push_exp(K_CANCEL, 0);
                        m_digits.delete();
                    end
                end else if (m_idle == TO - 1) begin
                    push_exp(K_TIMEOUT, 0);
                    m_digits.delete();
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            int nh, kind, ecount;
            bit ebusy;
            exp_t e;
            while (exp_q.size() > 0 && exp_q[0].edge_at < edge_n) begin
                checks++; failures++;
                $display("FAIL missed_pulse: kind %0d expected at edge %0d, still pending at edge %0d",
                         exp_q[0].kind, exp_q[0].edge_at, edge_n);
                void'(exp_q.pop_front());
            end
            ecount = m_digits.size();
            ebusy  = (m_mode == M_CONV) || (m_mode == M_DONE);
            checks++;
            if (digit_count !== 3'(ecount) || busy !== ebusy) begin
                failures++;
                $display("FAIL status @edge %0d: digit_count=%0d busy=%0b, required digit_count=%0d busy=%0b",
                         edge_n, digit_count, busy, ecount, ebusy);
            end
            nh = int'(pin_valid) + int'(pin_error) + int'(pin_cancel) + int'(pin_timeout);
            if (nh > 1 || (!pin_valid && pin_value !== '0)) begin
                checks++; failures++;
                $display("FAIL pulse_excl @edge %0d: v=%0b e=%0b c=%0b t=%0b value=%0d, required at most one pulse and value 0 unless valid",
                         edge_n, pin_valid, pin_error, pin_cancel, pin_timeout, pin_value);
            end else if (nh == 1) begin
                kind = pin_valid ? K_VALID : pin_error ? K_ERROR : pin_cancel ? K_CANCEL : K_TIMEOUT;
                if (pin_valid) begin n_valid++; last_value = int'(pin_value); end
                if (pin_error) n_error++;
                if (pin_cancel) n_cancel++;
                if (pin_timeout) n_timeout++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse @edge %0d: kind %0d value %0d, required no pulse",
                             edge_n, kind, pin_value);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || e.edge_at != edge_n || (kind == K_VALID && int'(pin_value) != e.value)) begin
                        failures++;
                        $display("FAIL pulse_match @edge %0d: kind %0d value %0d, required kind %0d value %0d at edge %0d",
                                 edge_n, kind, pin_value, e.kind, e.value, e.edge_at);
                    end
                end
            end
        end
    end

    task automatic cycle(input bit kv, input int kc, input bit cp);
        key_valid = kv; key_code = 4'(kc); card_present = cp;
        @(posedge clk);
        edge_n++;
        model_step(kv, kc, cp);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            edge_n++;
            model_reset();
            mon_en = 1'b1;
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic key(input int kc);
        cycle(1'b1, kc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 1'b1);
    endtask

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        int nv, nt, ne, r;
        do_reset(3);
        check_eq("reset_outputs", int'({pin_valid, pin_error, pin_cancel, pin_timeout, busy, digit_count, pin_value}), 0);
        idle(2);

        // 8030
        key(8); key(0); key(3); key(0); key(12); idle(8);
        check_eq("pin_8030", last_value, 8030);
        check_eq("count_after_done", int'(digit_count), 0);

        // backspace then 1567, then short ENTER
        key(1); key(2); key(11); key(5); key(6); key(7); key(12); idle(7);
        check_eq("pin_1567", last_value, 1567);
        nv = n_valid; ne = n_error;
        key(9); key(9); key(12); idle(2);
        check_eq("short_enter_error", n_error - ne, 1);
        check_eq("short_enter_no_valid", n_valid - nv, 0);
        check_eq("count_after_error", int'(digit_count), 0);

        // overfill then 1234, backspace on empty
        key(1); key(2); key(3); key(4); key(5);
        check_eq("count_saturates", int'(digit_count), ND);
        key(12); idle(7);
        check_eq("pin_1234", last_value, 1234);
        key(11);
        check_eq("bksp_empty", int'(digit_count), 0);

        // timeout, then a key exactly in the expiry cycle
        nt = n_timeout;
        key(7); idle(TO); idle(1);
        check_eq("timeout_single", n_timeout - nt, 1);
        check_eq("count_after_timeout", int'(digit_count), 0);
        key(7); idle(TO - 1); key(3); idle(2);
        check_eq("key_beats_timeout", n_timeout - nt, 1);
        key(10);

        // card pulled mid-conversion
        nv = n_valid;
        key(5); key(5); key(5); key(5); key(12); idle(2);
        cycle(1'b0, 0, 1'b0);
        check_eq("card_pull_outputs", int'({pin_valid, pin_error, pin_cancel, pin_timeout, busy, digit_count}), 0);
        idle(8);
        check_eq("card_pull_no_valid", n_valid - nv, 0);

        // reset mid-conversion
        key(6); key(6); key(6); key(6); key(12); idle(1);
        do_reset(1);
        idle(8);
        check_eq("reset_abort_no_valid", n_valid - nv, 0);

        // cancel, then keys ignored during conversion
        key(2); key(2); key(13); idle(1);
        check_eq("cancel_clears", int'(digit_count), 0);
        key(4); key(3); key(2); key(1); key(12); key(9); key(13); key(10); idle(6);
        check_eq("pin_4321_keys_ignored", last_value, 4321);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) repeat ($urandom_range(1, 3)) cycle(1'b0, 0, 1'b0);
            else if (r < 3) do_reset(1);
            else if (r < 55) key(int'($urandom_range(0, 9)));
            else if (r < 68) key(12);
            else if (r < 78) key(int'($urandom_range(10, 15)));
            else if (r < 80) idle(int'($urandom_range(TO - 2, TO + 2)));
            else idle(int'($urandom_range(1, 4)));
        end
        idle(10);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
